task_dispatcher: RTL and testbench
==================================

Name: task_dispatcher

Overview:
- Downstream stage of the task manager. Accepts 32-bit task words over a valid/ready handshake and launches each one on one of NUM_UNITS compute units with a one-cycle start pulse.
- Tracks per-unit busy state and a per-unit watchdog.
- Reports every task's completion on a single valid/ready completion channel with a status code.

Parameters:
- NUM_UNITS, 4, number of compute units; legal 1..4.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; legal 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- task_id  in  32  task word: [31:28] opcode, [27:26] unit select, [25:0] argument
- task_valid  in  1  task word valid
- task_ready  out  1  dispatcher can accept a task word
- unit_start  out  NUM_UNITS  one-cycle launch pulse, one bit per unit
- unit_cmd  out  32  task word for the launched unit; valid while any unit_start bit is high
- unit_done  in  NUM_UNITS  per-unit single-cycle completion pulse
- cpl_valid  out  1  completion record valid
- cpl_id  out  32  task word of the completed task
- cpl_status  out  2  0=OK, 1=TIMEOUT, 2=BAD_UNIT, 3=reserved
- cpl_ready  in  1  completion consumer ready
- busy_mask  out  NUM_UNITS  per-unit busy flags
- spurious_done  out  1  sticky flag: a unit_done arrived for an idle unit

Behaviour:
- Reset: all outputs 0; the hold register, busy flags, pending flags and watchdogs are all cleared. Asserting reset mid-task abandons the task silently; no completion is produced for it.
- Hold register (1 entry):
  - task_ready = !hold_valid, registered-state only, with no combinational path from task_valid.
  - Accept on task_valid && task_ready; the word is captured into hold at that edge.
- Launch from hold (evaluated every cycle hold_valid=1); let u = hold[27:26]:
  - opcode 4'hF (NOP): no launch. Hold becomes an immediate completion with status OK.
  - u >= NUM_UNITS: no launch. Immediate completion with status BAD_UNIT.
  - Otherwise, if busy[u]=0 and pend[u]=0:
    - unit_start[u]=1 for exactly one cycle, with unit_cmd=hold.
    - busy[u], unit_tid[u] and wd[u]=0 are set and hold is cleared, all at that edge.
  - Otherwise hold stalls and task_ready stays 0.
  - Minimum latency: accept at edge N, so unit_start is high in cycle N+1 and task_ready is 1 again in cycle N+2.
- Per-unit tracking, while busy[u]=1:
  - wd[u] increments every cycle.
  - unit_done[u]: busy cleared; pend[u] set with status OK.
  - wd[u] reaching TIMEOUT_CYCLES-1 without done: busy cleared; pend[u] set with status TIMEOUT.
  - Done and timeout in the same cycle: done wins (status OK).
  - unit_done[u] with busy[u]=0: ignored, spurious_done set; it is cleared only by reset.
  - busy_mask = busy (pend excluded).
- Completion register:
  - When cpl_valid=0, or cpl_valid && cpl_ready in this cycle, load the next source at the edge.
  - Priority: lowest-index pend[u] first, then an immediate completion held in hold.
  - Loading pend[u] clears pend[u]; loading the hold completion clears hold.
  - cpl_id, cpl_status and cpl_valid stay stable while cpl_valid && !cpl_ready.
  - Back-to-back completions at one per cycle when cpl_ready is held 1.
- Ordering: completions are in finish order, not issue order. A unit cannot be relaunched until its pend record has drained, so no record is ever overwritten.
- Watchdog is 16 bits wide and does not wrap; it is only active while busy.

Test Plan:
- Launch and done: task 32'h0400_0010 (unit 1). Expect unit_start=4'b0010 in cycle N+1 with unit_cmd=32'h0400_0010. Pulse unit_done[1] 5 cycles later. Expect cpl_valid with cpl_id=32'h0400_0010, status 0, and busy_mask back to 0.
- Busy stall: two tasks to unit 0. Expect the second to wait in hold with task_ready=0 until the first's completion is drained. The second unit_start[0] comes the cycle after pend clears.
- NOP and bad unit with NUM_UNITS=2: task 32'hF000_0000 gives status 0 with no unit_start. Task 32'h0C00_0001 (unit 3) gives status 2 with no unit_start.
- Timeout with TIMEOUT_CYCLES=8: launch on unit 2 and never assert done. Expect status 1 for that task_id, with busy[2] cleared 8 cycles after launch. A later unit_done[2] sets spurious_done.
- Back-pressure and simultaneous done: hold cpl_ready=0 and pulse unit_done[0] and unit_done[3] in the same cycle. cpl shows unit 0's task and stays stable. Raising cpl_ready drains unit 0's record, then unit 3's on consecutive cycles.
- Reset mid-operation: deassert rst_n while unit 1 is busy and cpl_valid=1. All outputs read 0 and no stale completion appears after reset is released.

Source files
------------

// File: rtl/task_dispatcher.sv
// Task dispatcher: a one-entry hold register feeds NUM_UNITS compute units.
// Each unit has a busy flag, a watchdog and a pending-completion record.
// All completions leave on one valid/ready channel in the order the units finish.
module task_dispatcher #(
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          task_id,
    input  logic                 task_valid,
    output logic                 task_ready,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [31:0]          unit_cmd,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 cpl_valid,
    output logic [31:0]          cpl_id,
    output logic [1:0]           cpl_status,
    input  logic                 cpl_ready,
    output logic [NUM_UNITS-1:0] busy_mask,
    output logic                 spurious_done
);

    localparam logic [1:0]  ST_OK       = 2'd0;
    localparam logic [1:0]  ST_TIMEOUT  = 2'd1;
    localparam logic [1:0]  ST_BAD_UNIT = 2'd2;
    localparam logic [3:0]  OP_NOP      = 4'hF;
    localparam logic [2:0]  UNITS_W     = 3'(NUM_UNITS);
    localparam logic [15:0] WD_LIMIT    = 16'(TIMEOUT_CYCLES - 1);

    logic                 ready_q, ready_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [31:0]          hold_q, hold_d;
    logic [NUM_UNITS-1:0] busy_q, busy_d;
    logic [NUM_UNITS-1:0] pend_q, pend_d;
    logic [31:0]          unit_tid_q [NUM_UNITS];
    logic [31:0]          unit_tid_d [NUM_UNITS];
    logic [15:0]          wd_q [NUM_UNITS];
    logic [15:0]          wd_d [NUM_UNITS];
    logic [1:0]           pend_st_q [NUM_UNITS];
    logic [1:0]           pend_st_d [NUM_UNITS];
    logic                 cpl_valid_q, cpl_valid_d;
    logic [31:0]          cpl_id_q, cpl_id_d;
    logic [1:0]           cpl_status_q, cpl_status_d;
    logic                 spurious_q, spurious_d;

    logic [1:0]           hold_unit;
    logic                 hold_nop;
    logic                 hold_bad;
    logic                 hold_imm;
    logic [NUM_UNITS-1:0] launch;
    logic                 pend_found;
    logic [NUM_UNITS-1:0] pend_sel;
    logic [31:0]          pend_tid;
    logic [1:0]           pend_stat;

    // Decode the held word: NOP / bad unit become immediate completions, otherwise launch when the unit is free.
    always_comb begin
        hold_unit = hold_q[27:26];
        hold_nop  = (hold_q[31:28] == OP_NOP);
        hold_bad  = !hold_nop && ({1'b0, hold_unit} >= UNITS_W);
        hold_imm  = hold_valid_q && (hold_nop || hold_bad);
        launch    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            launch[i] = hold_valid_q && !hold_nop && (hold_unit == 2'(i))
                        && !busy_q[i] && !pend_q[i];
        end
    end

    // Lowest-index pending record wins the completion channel.
    always_comb begin
        pend_found = 1'b0;
        pend_sel   = '0;
        pend_tid   = '0;
        pend_stat  = ST_OK;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (pend_q[i] && !pend_found) begin
                pend_found  = 1'b1;
                pend_sel[i] = 1'b1;
                pend_tid    = unit_tid_q[i];
                pend_stat   = pend_st_q[i];
            end
        end
    end

    // Next state for hold, units, watchdogs and the completion register.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        busy_d       = busy_q;
        pend_d       = pend_q;
        unit_tid_d   = unit_tid_q;
        wd_d         = wd_q;
        pend_st_d    = pend_st_q;
        cpl_valid_d  = cpl_valid_q;
        cpl_id_d     = cpl_id_q;
        cpl_status_d = cpl_status_q;
        spurious_d   = spurious_q;

        if (!cpl_valid_q || cpl_ready) begin
            cpl_valid_d = 1'b0;
            if (pend_found) begin
                cpl_valid_d  = 1'b1;
                cpl_id_d     = pend_tid;
                cpl_status_d = pend_stat;
                pend_d       = pend_q & ~pend_sel;
            end else if (hold_imm) begin
                cpl_valid_d  = 1'b1;
                cpl_id_d     = hold_q;
                cpl_status_d = hold_nop ? ST_OK : ST_BAD_UNIT;
                hold_valid_d = 1'b0;
            end
        end

        for (int i = 0; i < NUM_UNITS; i++) begin
            if (busy_q[i]) begin
                if (unit_done[i]) begin
                    busy_d[i]    = 1'b0;
                    pend_d[i]    = 1'b1;
                    pend_st_d[i] = ST_OK;
                end else if (wd_q[i] == WD_LIMIT) begin
                    busy_d[i]    = 1'b0;
                    pend_d[i]    = 1'b1;
                    pend_st_d[i] = ST_TIMEOUT;
                end else begin
                    wd_d[i] = wd_q[i] + 16'd1;
                end
            end else if (unit_done[i]) begin
                spurious_d = 1'b1;
            end
            if (launch[i]) begin
                busy_d[i]     = 1'b1;
                unit_tid_d[i] = hold_q;
                wd_d[i]       = 16'd0;
                hold_valid_d  = 1'b0;
            end
        end

        // Accept only when hold is empty; never overlaps with hold being cleared.
        if (task_valid && ready_q) begin
            hold_valid_d = 1'b1;
            hold_d       = task_id;
        end

        // Ready is a flop so it reads 0 in reset and has no path from task_valid.
        ready_d = !hold_valid_d;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            busy_q       <= '0;
            pend_q       <= '0;
            cpl_valid_q  <= 1'b0;
            cpl_id_q     <= '0;
            cpl_status_q <= ST_OK;
            spurious_q   <= 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                unit_tid_q[i] <= '0;
                wd_q[i]       <= '0;
                pend_st_q[i]  <= ST_OK;
            end
        end else begin
            ready_q      <= ready_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            cpl_valid_q  <= cpl_valid_d;
            cpl_id_q     <= cpl_id_d;
            cpl_status_q <= cpl_status_d;
            spurious_q   <= spurious_d;
            for (int i = 0; i < NUM_UNITS; i++) begin
                unit_tid_q[i] <= unit_tid_d[i];
                wd_q[i]       <= wd_d[i];
                pend_st_q[i]  <= pend_st_d[i];
            end
        end
    end

    assign task_ready    = ready_q;
    assign unit_start    = launch;
    assign unit_cmd      = (|launch) ? hold_q : 32'd0;
    assign cpl_valid     = cpl_valid_q;
    assign cpl_id        = cpl_id_q;
    assign cpl_status    = cpl_status_q;
    assign busy_mask     = busy_q;
    assign spurious_done = spurious_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher with 3 units (so unit select 3 is a bad unit) and an 8-cycle watchdog.
module tb_task_dispatcher;

    localparam int N = 3;
    localparam int T = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   task_id;
    logic          task_valid;
    logic          task_ready;
    logic [N-1:0]  unit_start;
    logic [31:0]   unit_cmd;
    logic [N-1:0]  unit_done;
    logic          cpl_valid;
    logic [31:0]   cpl_id;
    logic [1:0]    cpl_status;
    logic          cpl_ready;
    logic [N-1:0]  busy_mask;
    logic          spurious_done;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: what each unit is doing, how many cycles it has been busy,
    // which finished records wait for the channel, and what the channel shows.
    bit          m_rdy, m_hv, m_cv, m_spur;
    logic [31:0] m_hw, m_cid;
    logic [1:0]  m_cst;
    bit          m_busy [4];
    bit          m_pend [4];
    int          m_age  [4];
    logic [31:0] m_tid  [4];
    logic [1:0]  m_pst  [4];

    task_dispatcher #(.NUM_UNITS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .task_id(task_id), .task_valid(task_valid),
        .task_ready(task_ready), .unit_start(unit_start), .unit_cmd(unit_cmd),
        .unit_done(unit_done), .cpl_valid(cpl_valid), .cpl_id(cpl_id),
        .cpl_status(cpl_status), .cpl_ready(cpl_ready), .busy_mask(busy_mask),
        .spurious_done(spurious_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rdy = 0; m_hv = 0; m_cv = 0; m_spur = 0;
        m_hw = '0; m_cid = '0; m_cst = '0;
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_age[i] = 0; m_tid[i] = '0; m_pst[i] = '0;
        end
    endtask

    task automatic compare_outputs();
        logic [N-1:0] es, eb;
        logic [31:0]  ec;
        int           u;
        bit           nop;
        es = '0; eb = '0; ec = '0;
        u   = int'(m_hw[27:26]);
        nop = (m_hw[31:28] == 4'hF);
        if (m_hv && !nop && u < N && !m_busy[u] && !m_pend[u]) begin
            es[u] = 1'b1;
            ec    = m_hw;
        end
        for (int i = 0; i < N; i++) eb[i] = m_busy[i];
        check_val("task_ready", task_ready, m_rdy);
        check_val("unit_start", unit_start, es);
        check_val("unit_cmd", unit_cmd, ec);
        check_val("busy_mask", busy_mask, eb);
        check_val("cpl_valid", cpl_valid, m_cv);
        if (m_cv) begin
            check_val("cpl_id", cpl_id, m_cid);
            check_val("cpl_status", cpl_status, m_cst);
        end
        check_val("spurious_done", spurious_done, m_spur);
    endtask

    // Advance the model by one clock given the inputs present during the cycle.
    task automatic model_next(input logic tv, input logic [31:0] tw, input logic [N-1:0] dn, input logic cr);
        int u, sel;
        bit nop, bad, go, hold_gone;
        u   = int'(m_hw[27:26]);
        nop = (m_hw[31:28] == 4'hF);
        bad = !nop && (u >= N);
        go  = m_hv && !nop && !bad && !m_busy[u] && !m_pend[u];
        hold_gone = go;
        if (!m_cv || cr) begin
            sel = -1;
            for (int i = 0; i < N; i++) if (m_pend[i] && sel < 0) sel = i;
            if (sel >= 0) begin
                m_cv = 1; m_cid = m_tid[sel]; m_cst = m_pst[sel]; m_pend[sel] = 0;
            end else if (m_hv && (nop || bad)) begin
                m_cv = 1; m_cid = m_hw; m_cst = nop ? 2'd0 : 2'd2; hold_gone = 1;
            end else begin
                m_cv = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
                if (dn[i]) begin
                    m_busy[i] = 0; m_pend[i] = 1; m_pst[i] = 2'd0;
                end else if (m_age[i] + 1 == T) begin
                    m_busy[i] = 0; m_pend[i] = 1; m_pst[i] = 2'd1;
                end else begin
                    m_age[i]++;
                end
            end else if (dn[i]) begin
                m_spur = 1;
            end
        end
        if (go) begin
            m_busy[u] = 1; m_age[u] = 0; m_tid[u] = m_hw;
        end
        if (m_rdy && tv) begin
            m_hv = 1; m_hw = tw;
        end else if (hold_gone) begin
            m_hv = 0;
        end
        m_rdy = !m_hv;
    endtask

    // One clock: drive inputs, update the model, then compare after the edge.
    task automatic step(input logic tv, input logic [31:0] tw, input logic [N-1:0] dn, input logic cr);
        task_valid = tv; task_id = tw; unit_done = dn; cpl_ready = cr;
        model_next(tv, tw, dn, cr);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        task_valid = 1'b0; task_id = '0; unit_done = '0; cpl_ready = 1'b0;
        model_reset();
        #2;
        check_val("rst_task_ready", task_ready, 0);
        check_val("rst_unit_start", unit_start, 0);
        check_val("rst_unit_cmd", unit_cmd, 0);
        check_val("rst_cpl_valid", cpl_valid, 0);
        check_val("rst_cpl_id", cpl_id, 0);
        check_val("rst_cpl_status", cpl_status, 0);
        check_val("rst_busy_mask", busy_mask, 0);
        check_val("rst_spurious", spurious_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_rdy = 1;
        compare_outputs();
    endtask

    initial begin
        logic [31:0]  w;
        logic [N-1:0] d;
        int           cnt;

        do_reset();

        // Randomized traffic; done pulses only for busy units so spurious stays clear here.
        for (int c = 0; c < 1500; c++) begin
            w[31:28] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            w[27:26] = 2'($urandom_range(0, 3));
            w[25:0]  = 26'($urandom);
            d = '0;
            for (int i = 0; i < N; i++) d[i] = m_busy[i] && ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 2) != 0, w, d, $urandom_range(0, 3) != 0);
        end

        // Launch and done on unit 1.
        do_reset();
        step(1, 32'h0400_0010, 0, 1);
        check_val("t1_start", unit_start, 3'b010);
        check_val("t1_cmd", unit_cmd, 32'h0400_0010);
        check_val("t1_ready_low", task_ready, 0);
        step(0, 0, 0, 1);
        check_val("t1_ready_back", task_ready, 1);
        check_val("t1_busy", busy_mask, 3'b010);
        repeat (4) step(0, 0, 0, 1);
        step(0, 0, 3'b010, 1);
        step(0, 0, 0, 1);
        check_val("t1_cpl_valid", cpl_valid, 1);
        check_val("t1_cpl_id", cpl_id, 32'h0400_0010);
        check_val("t1_cpl_status", cpl_status, 0);
        check_val("t1_busy_clear", busy_mask, 0);
        step(0, 0, 0, 1);

        // Busy stall: a NOP occupies the channel while two tasks target unit 0.
        step(1, 32'hF000_0000, 0, 0);
        check_val("t2_nop_no_start", unit_start, 0);
        step(0, 0, 0, 0);
        check_val("t2_nop_status", cpl_status, 0);
        check_val("t2_nop_id", cpl_id, 32'hF000_0000);
        step(1, 32'h1000_0001, 0, 0);
        step(0, 0, 0, 0);
        step(1, 32'h2000_0002, 0, 0);
        step(0, 0, 3'b001, 0);
        repeat (3) begin
            step(0, 0, 0, 0);
            check_val("t2_stall_ready", task_ready, 0);
            check_val("t2_stall_start", unit_start, 0);
            check_val("t2_stall_cpl", cpl_id, 32'hF000_0000);
        end
        step(0, 0, 0, 1);
        check_val("t2_relaunch", unit_start, 3'b001);
        check_val("t2_relaunch_cmd", unit_cmd, 32'h2000_0002);
        check_val("t2_first_cpl", cpl_id, 32'h1000_0001);
        step(0, 0, 0, 1);
        check_val("t2_ready_back", task_ready, 1);
        step(0, 0, 3'b001, 1);
        step(0, 0, 0, 1);
        check_val("t2_second_cpl", cpl_id, 32'h2000_0002);
        step(0, 0, 0, 1);

        // Bad unit select.
        step(1, 32'h0C00_0001, 0, 1);
        check_val("t3_no_start", unit_start, 0);
        step(0, 0, 0, 1);
        check_val("t3_cpl_valid", cpl_valid, 1);
        check_val("t3_cpl_id", cpl_id, 32'h0C00_0001);
        check_val("t3_cpl_status", cpl_status, 2);
        step(0, 0, 0, 1);

        // Watchdog timeout on unit 2, then a late done is spurious.
        step(1, 32'h0800_0005, 0, 1);
        check_val("t4_start", unit_start, 3'b100);
        step(0, 0, 0, 1);
        cnt = 0;
        while (busy_mask[2] && cnt < 20) begin
            cnt++;
            step(0, 0, 0, 1);
        end
        check_val("t4_busy_cycles", cnt, T);
        step(0, 0, 0, 1);
        check_val("t4_cpl_id", cpl_id, 32'h0800_0005);
        check_val("t4_cpl_status", cpl_status, 1);
        check_val("t4_spur_before", spurious_done, 0);
        step(0, 0, 3'b100, 1);
        check_val("t4_spur_after", spurious_done, 1);
        step(0, 0, 0, 1);

        // Back-pressure with simultaneous done on units 0 and 2.
        step(1, 32'h0000_0100, 0, 1);
        step(0, 0, 0, 1);
        step(1, 32'h0800_0200, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 3'b101, 0);
        step(0, 0, 0, 0);
        check_val("t5_first", cpl_id, 32'h0000_0100);
        repeat (2) begin
            step(0, 0, 0, 0);
            check_val("t5_stable_valid", cpl_valid, 1);
            check_val("t5_stable_id", cpl_id, 32'h0000_0100);
        end
        step(0, 0, 0, 1);
        check_val("t5_second", cpl_id, 32'h0800_0200);
        check_val("t5_second_status", cpl_status, 0);
        step(0, 0, 0, 1);
        check_val("t5_drained", cpl_valid, 0);

        // Reset while unit 1 is busy and a completion is waiting.
        step(1, 32'h0400_0077, 0, 0);
        step(1, 32'hF000_0001, 0, 0);
        step(1, 32'hF000_0001, 0, 0);
        step(0, 0, 0, 0);
        check_val("t6_pre_busy", busy_mask, 3'b010);
        check_val("t6_pre_cpl", cpl_valid, 1);
        do_reset();
        repeat (10) begin
            step(0, 0, 0, 1);
            check_val("t6_no_stale", cpl_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
